dds_sweep_ctrl: RTL and testbench

//  Sequences the phaseInc input of the DDS core to produce a stepped linear

---
 rtl/dds_sweep_ctrl.sv | 147 ++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Stepped linear frequency sweep sequencer driving the DDS phase increment.
// Define SWEEP_BIDIR_EN to build the triangle (up then down) sweep.
module dds_sweep_ctrl #(
    parameter int psz = 32,
    parameter int dsz = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [psz-1:0] cfg_start_inc,
    input  logic [psz-1:0] cfg_stop_inc,
    input  logic [psz-1:0] cfg_step,
    input  logic [dsz-1:0] cfg_dwell,
    input  logic           cfg_loop,
    output logic [psz-1:0] phase_inc,
    output logic           busy,
    output logic           done,
    output logic           wrap
);

`ifdef SWEEP_BIDIR_EN
    typedef enum logic [1:0] {IDLE, RUN, DOWN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t         state;
    logic [psz-1:0] start_r;
    logic [psz-1:0] stop_r;
    logic [psz-1:0] step_r;
    logic [dsz-1:0] dwell_r;
    logic           loop_r;
    logic [dsz-1:0] dwell_cnt;

    logic [psz:0]   up_sum;
    logic [psz-1:0] up_nxt;
    logic           degen;
    logic           ramp_end;

    // Carry out of the adder means we passed stop, so clamp to it.
    assign up_sum   = {1'b0, phase_inc} + {1'b0, step_r};
    assign up_nxt   = (up_sum >= {1'b0, stop_r}) ? stop_r : up_sum[psz-1:0];
    assign degen    = (step_r == '0) || (start_r >= stop_r);
    assign ramp_end = degen || (phase_inc == stop_r);

`ifdef SWEEP_BIDIR_EN
    logic [psz:0]   dn_diff;
    logic [psz-1:0] dn_nxt;
    logic [psz:0]   rs_sum;
    logic [psz-1:0] rs_nxt;

    assign dn_diff = {1'b0, phase_inc} - {1'b0, step_r};
    assign dn_nxt  = (dn_diff[psz] || (dn_diff[psz-1:0] <= start_r))
                     ? start_r : dn_diff[psz-1:0];
    // Restarting from the bottom turn skips start so it is not repeated.
    assign rs_sum  = {1'b0, start_r} + {1'b0, step_r};
    assign rs_nxt  = (rs_sum >= {1'b0, stop_r}) ? stop_r : rs_sum[psz-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase_inc <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            start_r   <= '0;
            stop_r    <= '0;
            step_r    <= '0;
            dwell_r   <= '0;
            loop_r    <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                phase_inc <= '0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            start_r   <= cfg_start_inc;
                            stop_r    <= cfg_stop_inc;
                            step_r    <= cfg_step;
                            dwell_r   <= cfg_dwell;
                            loop_r    <= cfg_loop;
                            phase_inc <= cfg_start_inc;
                            dwell_cnt <= cfg_dwell;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (dwell_cnt != '0) begin
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end else if (!ramp_end) begin
                            phase_inc <= up_nxt;
                            dwell_cnt <= dwell_r;
`ifdef SWEEP_BIDIR_EN
                        end else if (!degen) begin
                            phase_inc <= dn_nxt;
                            dwell_cnt <= dwell_r;
                            state     <= DOWN;
`endif
                        end else if (loop_r) begin
                            phase_inc <= start_r;
                            dwell_cnt <= dwell_r;
                            wrap      <= 1'b1;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
`ifdef SWEEP_BIDIR_EN
                    DOWN: begin
                        if (dwell_cnt != '0) begin
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end else if (phase_inc != start_r) begin
                            phase_inc <= dn_nxt;
                            dwell_cnt <= dwell_r;
                        end else if (loop_r) begin
                            phase_inc <= rs_nxt;
                            dwell_cnt <= dwell_r;
                            wrap      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
`endif
                    default: begin
                        state     <= IDLE;
                        phase_inc <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed scoreboard bench for dds_sweep_ctrl; expectations are queued
// per cycle and checked 1 time unit after each rising edge.
module tb_dds_sweep_ctrl;

    typedef struct packed {
        logic [31:0] ph;
        logic        busy;
        logic        done;
        logic        wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_start_inc = '0;
    logic [31:0] cfg_stop_inc = '0;
    logic [31:0] cfg_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic        cfg_loop = 1'b0;
    logic [31:0] phase_inc;
    logic        busy;
    logic        done;
    logic        wrap;

    exp_t  sb[$];
    int    tests = 0;
    int    fails = 0;
    string tag = "reset";

    dds_sweep_ctrl #(.psz(32), .dsz(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_start_inc (cfg_start_inc),
        .cfg_stop_inc  (cfg_stop_inc),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_loop      (cfg_loop),
        .phase_inc     (phase_inc),
        .busy          (busy),
        .done          (done),
        .wrap          (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Push expected outputs after the next edge, then advance and check.
    task automatic tick(input logic [31:0] ph, input logic b,
                        input logic d, input logic w);
        exp_t e;
        exp_t o;
        sb.push_back('{ph, b, d, w});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = '{phase_inc, busy, done, wrap};
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: got ph=%h busy=%b done=%b wrap=%b, want ph=%h busy=%b done=%b wrap=%b",
                   tag, o.ph, o.busy, o.done, o.wrap,
                   e.ph, e.busy, e.done, e.wrap);
        end
    endtask

    task automatic cfg(input logic [31:0] s, input logic [31:0] e,
                       input logic [31:0] st, input logic [15:0] d,
                       input logic l);
        cfg_start_inc = s;
        cfg_stop_inc  = e;
        cfg_step      = st;
        cfg_dwell     = d;
        cfg_loop      = l;
    endtask

    task automatic run(input logic [31:0] v);
        tick(v, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        tick(32'd0, 1'b0, 1'b0, 1'b0);
        tick(32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(32'd0, 1'b0, 1'b0, 1'b0);

`ifdef SWEEP_BIDIR_EN
        tag = "triangle";
        cfg(32'd0, 32'd30, 32'd10, 16'd0, 1'b0);
        start = 1'b1;
        run(32'd0);
        start = 1'b0;
        run(32'd10);
        run(32'd20);
        run(32'd30);
        run(32'd20);
        run(32'd10);
        run(32'd0);
        tick(32'd0, 1'b0, 1'b1, 1'b0);
        tick(32'd0, 1'b0, 1'b0, 1'b0);

        tag = "tri_loop";
        cfg(32'd5, 32'd7, 32'd1, 16'd0, 1'b1);
        start = 1'b1;
        run(32'd5);
        start = 1'b0;
        run(32'd6);
        run(32'd7);
        run(32'd6);
        run(32'd5);
        tick(32'd6, 1'b1, 1'b0, 1'b1);
        run(32'd7);
        run(32'd6);
        run(32'd5);
        tick(32'd6, 1'b1, 1'b0, 1'b1);
        abort = 1'b1;
        tick(32'd0, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;
`else
        tag = "oneshot";
        cfg(32'd100, 32'd130, 32'd10, 16'd1, 1'b0);
        start = 1'b1;
        run(32'd100);
        start = 1'b0;
        cfg(32'd7, 32'd9, 32'd1, 16'd0, 1'b1);
        run(32'd100);
        run(32'd110);
        start = 1'b1;
        run(32'd110);
        start = 1'b0;
        run(32'd120);
        run(32'd120);
        run(32'd130);
        run(32'd130);
        tick(32'd130, 1'b0, 1'b1, 1'b0);
        tick(32'd130, 1'b0, 1'b0, 1'b0);

        tag = "clamp";
        cfg(32'd0, 32'd25, 32'd10, 16'd0, 1'b0);
        start = 1'b1;
        run(32'd0);
        start = 1'b0;
        run(32'd10);
        run(32'd20);
        run(32'd25);
        tick(32'd25, 1'b0, 1'b1, 1'b0);

        tag = "overflow";
        cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 1'b0);
        start = 1'b1;
        run(32'hFFFF_FFF0);
        start = 1'b0;
        run(32'hFFFF_FFFF);
        tick(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);

        tag = "loop";
        cfg(32'd5, 32'd7, 32'd1, 16'd0, 1'b1);
        start = 1'b1;
        run(32'd5);
        start = 1'b0;
        run(32'd6);
        run(32'd7);
        tick(32'd5, 1'b1, 1'b0, 1'b1);
        run(32'd6);
        run(32'd7);
        tick(32'd5, 1'b1, 1'b0, 1'b1);
        run(32'd6);
        abort = 1'b1;
        tick(32'd0, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;
`endif

        tag = "abort";
        cfg(32'd100, 32'd130, 32'd10, 16'd1, 1'b0);
        start = 1'b1;
        run(32'd100);
        start = 1'b0;
        run(32'd100);
        abort = 1'b1;
        tick(32'd0, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;
        tick(32'd0, 1'b0, 1'b0, 1'b0);

        tag = "start_abort";
        start = 1'b1;
        abort = 1'b1;
        tick(32'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        tick(32'd0, 1'b0, 1'b0, 1'b0);

        tag = "degenerate";
        cfg(32'd50, 32'd40, 32'd3, 16'd2, 1'b1);
        start = 1'b1;
        run(32'd50);
        start = 1'b0;
        run(32'd50);
        run(32'd50);
        tick(32'd50, 1'b1, 1'b0, 1'b1);
        run(32'd50);
        run(32'd50);
        tick(32'd50, 1'b1, 1'b0, 1'b1);
        abort = 1'b1;
        tick(32'd0, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;

        tag = "step0";
        cfg(32'd9, 32'd90, 32'd0, 16'd1, 1'b0);
        start = 1'b1;
        run(32'd9);
        start = 1'b0;
        run(32'd9);
        tick(32'd9, 1'b0, 1'b1, 1'b0);

        tag = "rst_mid";
        cfg(32'd1, 32'd100, 32'd1, 16'd0, 1'b0);
        start = 1'b1;
        run(32'd1);
        start = 1'b0;
        run(32'd2);
        rst = 1'b1;
        tick(32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(32'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
